// File: rtl/collatz_pin_host.sv
// collatz_pin_host: host-side sequencer for the Collatz core pin protocol.
// It accepts a seed, loads it byte-wise (LSB first), waits for busy to fall,
// then reads back steps[15:0] and peak[WIDTH-1:0] and presents them.
// Optional feature: define COLLATZ_HOST_TIMEOUT_EN to bound the busy wait
// to TIMEOUT_CYCLES cycles (result is then an error with steps=0xFFFF).
module collatz_pin_host #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] start_value,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_steps,
  output logic [WIDTH-1:0] res_peak,
  output logic             res_error,
  output logic [7:0]       pin_ui,
  output logic [1:0]       pin_cmd,
  input  logic [7:0]       pin_uo,
  input  logic             pin_busy
);

  localparam int NB = WIDTH / 8;
  localparam int NR = 2 + NB;
`ifdef COLLATZ_HOST_TIMEOUT_EN
  // counter doubles as the WAIT cycle counter, so it must reach TIMEOUT_CYCLES
  localparam int CW = $clog2(((TIMEOUT_CYCLES > NR) ? TIMEOUT_CYCLES : NR) + 2);
`else
  localparam int CW = $clog2(NR + 2);
`endif

  // elaboration-time guard on the legal parameter range
  if (WIDTH % 8 != 0 || WIDTH < 8 || WIDTH > 64 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("collatz_pin_host: illegal WIDTH or TIMEOUT_CYCLES");
  end

  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_LOAD = 2'b01;
  localparam logic [1:0] CMD_READ = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_WAIT, S_READ, S_RESULT
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] seed_sh;          // seed bytes still to be sent, next byte at LSB
  logic [8*NR-1:0]  rd_buf, rd_shift; // read-back bytes, first byte ends at LSB
  logic [1:0]       cmd_n;
  logic [7:0]       ui_n;
  logic             load_res, err_n;
  logic [15:0]      steps_n;
  logic [WIDTH-1:0] peak_n;

  // state and sequence counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // next state, result capture and next pin values (registered below)
  always_comb begin
    state_n  = state;
    cmd_n    = CMD_IDLE;
    ui_n     = 8'h00;
    load_res = 1'b0;
    err_n    = 1'b0;
    steps_n  = '0;
    peak_n   = '0;
    rd_shift = {pin_uo, rd_buf[8*NR-1:8]};
    case (state)
      S_IDLE: begin
        if (start_valid) begin
          if (start_value == '0) begin
            // zero seed never touches the pins
            state_n  = S_RESULT;
            load_res = 1'b1;
            err_n    = 1'b1;
          end else begin
            state_n = S_LOAD;
          end
        end
      end
      S_LOAD:   if (cnt == CW'(NB - 1)) state_n = S_SETTLE;
      S_SETTLE: state_n = S_WAIT;
      S_WAIT: begin
        if (!pin_busy) state_n = S_READ;
`ifdef COLLATZ_HOST_TIMEOUT_EN
        // cnt is the 0-based WAIT cycle index; this is the last allowed one
        else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          state_n  = S_RESULT;
          load_res = 1'b1;
          err_n    = 1'b1;
          steps_n  = 16'hFFFF;
        end
`endif
      end
      S_READ: begin
        // cnt==NR is the capture of the last byte; take it straight from the pins
        if (cnt == CW'(NR)) begin
          state_n  = S_RESULT;
          load_res = 1'b1;
          steps_n  = rd_shift[15:0];
          peak_n   = rd_shift[16 +: WIDTH];
        end
      end
      S_RESULT: if (res_ready) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase

    cnt_n = (state_n != state) ? '0 : cnt + 1'b1;
`ifndef COLLATZ_HOST_TIMEOUT_EN
    // no timeout: the counter idles during WAIT
    if (state == S_WAIT && state_n == S_WAIT) cnt_n = cnt;
`endif

    if (state_n == S_LOAD) begin
      cmd_n = CMD_LOAD;
      ui_n  = (state == S_IDLE) ? start_value[7:0] : seed_sh[7:0];
    end
    // READ issues NR commands; its final cycle only captures
    if (state_n == S_READ && cnt_n < CW'(NR)) cmd_n = CMD_READ;
  end

  // seed shifter and read-back capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seed_sh <= '0;
      rd_buf  <= '0;
    end else begin
      if (state == S_IDLE && start_valid) seed_sh <= start_value >> 8;
      else if (state == S_LOAD)           seed_sh <= seed_sh >> 8;
      if (state == S_READ && cnt != '0)   rd_buf  <= rd_shift;
    end
  end

  // registered outputs, decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_ready <= 1'b1;
      res_valid   <= 1'b0;
      res_steps   <= '0;
      res_peak    <= '0;
      res_error   <= 1'b0;
      pin_ui      <= '0;
      pin_cmd     <= CMD_IDLE;
    end else begin
      start_ready <= (state_n == S_IDLE);
      res_valid   <= (state_n == S_RESULT);
      pin_cmd     <= cmd_n;
      pin_ui      <= ui_n;
      if (load_res) begin
        res_steps <= steps_n;
        res_peak  <= peak_n;
        res_error <= err_n;
      end
    end
  end

endmodule

// File: doc/collatz_pin_host.md
# collatz_pin_host

Host-side sequencer for the Collatz core's Tiny Tapeout pin protocol. It takes a start value over a valid/ready handshake, loads it into the core byte-by-byte, waits for the core to finish iterating, then reads back the step count and peak value. It sits on the far side of the chip pins: it is used on the FPGA/demo board and as the protocol master in system-level benches.

## Interface
- `WIDTH`, 32: start/peak value width in bits; a multiple of 8, range 8..64. NB = WIDTH/8.
- `TIMEOUT_CYCLES`, 65535: maximum cycles to wait for busy to fall (only with timeout feature).
- `clk`  in  1  system clock; same clock as the core.
- `rst`  in  1  asynchronous, active-high reset.
- `start_valid`  in  1  start request.
- `start_ready`  out  1  host idle and can accept a request.
- `start_value`  in  WIDTH  Collatz seed.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_steps`  out  16  iteration count reported by the core.
- `res_peak`  out  WIDTH  peak value reported by the core.
- `res_error`  out  1  seed was 0, or the wait timed out.
- `pin_ui`  out  8  data byte to the core (`ui_in`).
- `pin_cmd`  out  2  command to the core (`uio_in[1:0]`): 00 idle, 01 LOAD, 10 READ, 11 reserved (never driven).
- `pin_uo`  in  8  data byte from the core (`uo_out`).
- `pin_busy`  in  1  core iterating (`uio_out[7]`).

## Operation
- States: IDLE, LOAD, SETTLE, WAIT, READ, RESULT.
- IDLE:
  - `start_ready`=1.
  - A transfer is accepted when `start_valid` and `start_ready` are both high. The seed is latched in that cycle.
  - Seed == 0: go directly to RESULT with `res_error`=1, steps=0, peak=0. No pin activity.
- LOAD: NB cycles. Each cycle drives `pin_cmd`=01 and `pin_ui`=seed byte i, LSB byte first.
- SETTLE: one cycle with `pin_cmd`=00. By protocol definition, the core raises busy no later than this cycle.
- WAIT: `pin_cmd`=00. Leave on the first cycle `pin_busy`==0 and go to READ.
- READ:
  - NR = 2+NB READ commands issued on consecutive cycles.
  - The core returns the byte for a READ on `pin_uo` in the following cycle. The host captures it then, while the next READ is in flight. State lasts NR+1 cycles.
  - Byte order: steps[7:0], steps[15:8], then peak bytes LSB first.
- RESULT:
  - `res_valid`=1. Outputs are held stable until `res_ready`, then return to IDLE.
  - `res_valid` and `start_ready` are never high together.
- Reset values: `start_ready`=1 after reset is released; `res_valid`=0; `res_steps`=0; `res_peak`=0; `res_error`=0; `pin_ui`=0; `pin_cmd`=00; state IDLE.
- Reset mid-transfer aborts immediately: `pin_cmd` goes to 00 asynchronously, and no partial result is presented.
- `start_valid` asserted outside IDLE is ignored; it is not queued.
- `pin_uo` is ignored outside the READ capture cycles.

## Timing
- Accept on cycle 0. LOAD occupies cycles 1..NB. SETTLE is cycle NB+1. WAIT starts at cycle NB+2.
- Busy observed low at cycle W: READ runs W+1..W+NR+1, and `res_valid` rises at W+NR+2.
- Minimum latency (busy already low in the first WAIT cycle) for WIDTH=32: accept→`res_valid` = 1+4+1+1+6+1 = 14 cycles.
- All outputs are registered; there are no combinational paths from inputs to pins.

## Configuration
- `COLLATZ_HOST_TIMEOUT_EN` defined:
  - A cycle counter runs in WAIT, cleared on entry.
  - When the counter reaches `TIMEOUT_CYCLES` with busy still high, the host goes to RESULT with `res_error`=1, steps=0xFFFF, peak=0, and skips READ.
- Not defined: WAIT is unbounded, the counter is absent, and `res_error` is set only for a zero seed.

## Test plan
- Seed 27, WIDTH=32, core model busy for 200 cycles:
  - LOAD bytes 1B,00,00,00 on cycles 1-4.
  - Result steps=111 (0x006F), peak=9232 (0x2410), `res_error`=0.
- Seed 1, core model never raises busy beyond SETTLE: `res_valid` exactly 14 cycles after accept; steps=0, peak=1.
- Seed 0: `res_valid` on cycle 1 with `res_error`=1; `pin_cmd` stays 00 throughout.
- `rst` asserted during LOAD byte 2:
  - `pin_cmd`=00 immediately; `start_ready`=1 after reset is released.
  - A following seed 7 completes with steps=16, peak=52.
- `res_ready` held low for 10 cycles in RESULT: outputs are stable, `start_ready`=0, and `start_valid` pulses are ignored.
- With `COLLATZ_HOST_TIMEOUT_EN` and `TIMEOUT_CYCLES`=50, busy held high: `res_error`=1 and steps=0xFFFF after exactly 50 WAIT cycles. No READ is issued.
